// File: rtl/tlb_fill_ctrl_pkg.sv
// Shared types and helpers for the TLB fill controller.
//   statetype    : fill FSM states
//   ent_vec_t    : entry vector wide enough for any supported TLB size
//   lowest_set   : index of the least-significant set bit (0 when none)
//   is_onehot    : exactly one bit set
package tlb_fill_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    ACK,
    DRAIN
  } statetype;

  // Upper bound on TLB_ENTRIES accepted by the helpers below.
  localparam int unsigned MaxEntries = 64;

  typedef logic [MaxEntries-1:0] ent_vec_t;

  function automatic int unsigned lowest_set(ent_vec_t v);
    int unsigned idx;
    idx = 0;
    // Scan from the top so the lowest set bit is the one that sticks.
    for (int i = MaxEntries - 1; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

  function automatic logic is_onehot(ent_vec_t v);
    return (v != '0) && ((v & (v - MaxEntries'(1))) == '0);
  endfunction

endpackage

// File: rtl/tlb_fill_ctrl_if.sv
// Bundle between a TLB (CAM/RAM + page-table walker) and its fill controller.
//   master : TLB side, drives lookup, fill and flush requests
//   slave  : fill controller, drives write strobes, valid bits, ack, hit and busy
interface tlb_fill_ctrl_if #(
  parameter int TLB_ENTRIES = 8
);
  logic                   TLBAccess;
  logic [TLB_ENTRIES-1:0] Matches;
  logic [TLB_ENTRIES-1:0] PTE_Gs;
  logic                   FillReq;
  logic                   FillAck;
  logic                   FlushReq;
  logic                   FlushAll;
  logic [TLB_ENTRIES-1:0] WriteEnables;
  logic [TLB_ENTRIES-1:0] Valid;
  logic                   TLBHit;
  logic                   Busy;

  modport master (
    output TLBAccess, Matches, PTE_Gs, FillReq, FlushReq, FlushAll,
    input  FillAck, WriteEnables, Valid, TLBHit, Busy
  );

  modport slave (
    input  TLBAccess, Matches, PTE_Gs, FillReq, FlushReq, FlushAll,
    output FillAck, WriteEnables, Valid, TLBHit, Busy
  );
endinterface

// File: rtl/tlb_plru.sv
// Tree pseudo-LRU replacement state for one TLB.
//   clk, reset   : clock, async active-high reset (all tree bits cleared)
//   touch_en_i   : mark touch_idx_i as most recently used this cycle
//   touch_idx_i  : entry being touched
//   victim_idx_o : entry the tree currently points at
//   victim_oh_o  : same, one-hot
// Node k (1-based heap order) is stored in bits_q[k-1]; a 0 bit points to the
// lower-index half, a 1 bit to the upper half.
module tlb_plru #(
  parameter int TLB_ENTRIES = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           touch_en_i,
  input  logic [$clog2(TLB_ENTRIES)-1:0] touch_idx_i,
  output logic [$clog2(TLB_ENTRIES)-1:0] victim_idx_o,
  output logic [TLB_ENTRIES-1:0]         victim_oh_o
);

  localparam int IdxW = $clog2(TLB_ENTRIES);

  logic [TLB_ENTRIES-2:0] bits_q, bits_d;
  int unsigned            tnode;
  logic                   tdir;
  int unsigned            vnode;
  logic                   vdir;

  // Every node on the touched entry's path is pointed at the other branch.
  always_comb begin
    bits_d = bits_q;
    tnode  = 1;
    tdir   = 1'b0;
    if (touch_en_i) begin
      for (int l = IdxW - 1; l >= 0; l--) begin
        tdir                          = touch_idx_i[l];
        bits_d[IdxW'(tnode - 1)]      = ~tdir;
        tnode                         = 2 * tnode + {31'b0, tdir};
      end
    end
  end

  always_comb begin
    victim_idx_o = '0;
    vnode        = 1;
    vdir         = 1'b0;
    for (int l = IdxW - 1; l >= 0; l--) begin
      vdir            = bits_q[IdxW'(vnode - 1)];
      victim_idx_o[l] = vdir;
      vnode           = 2 * vnode + {31'b0, vdir};
    end
  end

  assign victim_oh_o = TLB_ENTRIES'(1) << victim_idx_o;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bits_q <= '0;
    end else begin
      bits_q <= bits_d;
    end
  end

endmodule

// File: rtl/tlb_fill_ctrl.sv
// TLB fill controller: sequences PTE writes into the TLB entry RAM.
//   clk, reset : clock, async active-high reset
//   bus        : slave side of tlb_fill_ctrl_if
//                (lookup/fill/flush requests in; WriteEnables, Valid, FillAck,
//                 TLBHit, Busy out)
// Owns the per-entry valid bits and the PLRU tree. A fill request accepted in
// IDLE latches a victim (first invalid entry, else PLRU), strobes it for one
// cycle in WRITE, pulses FillAck in ACK, then waits in DRAIN for the request
// to drop so one request can never produce a second write.
module tlb_fill_ctrl
  import tlb_fill_ctrl_pkg::*;
#(
  parameter int TLB_ENTRIES = 8
) (
  input logic             clk,
  input logic             reset,
  tlb_fill_ctrl_if.slave  bus
);

  localparam int IdxW = $clog2(TLB_ENTRIES);

  statetype               state_q, state_d;
  logic [IdxW-1:0]        victim_q, victim_d;
  logic [TLB_ENTRIES-1:0] we_q, we_d;
  logic                   ack_q, ack_d;
  logic                   busy_q, busy_d;
  logic [TLB_ENTRIES-1:0] valid_q, valid_d;

  logic                   hit;
  logic [IdxW-1:0]        hit_idx;
  logic                   hit_onehot;
  logic                   any_inv;
  logic [TLB_ENTRIES-1:0] first_inv_oh;
  logic [IdxW-1:0]        first_inv_idx;
  logic [IdxW-1:0]        plru_idx;
  logic [TLB_ENTRIES-1:0] plru_oh;
  logic [IdxW-1:0]        sel_idx;
  logic [TLB_ENTRIES-1:0] sel_oh;
  logic                   write_touch;
  logic                   touch_en;
  logic [IdxW-1:0]        touch_idx;

  assign hit        = bus.TLBAccess & (|bus.Matches);
  assign hit_idx    = IdxW'(lowest_set(MaxEntries'(bus.Matches)));
  assign hit_onehot = is_onehot(MaxEntries'(bus.Matches));

  // Isolate the lowest clear bit of valid_q.
  assign any_inv       = ~(&valid_q);
  assign first_inv_oh  = ~valid_q & (valid_q + TLB_ENTRIES'(1));
  assign first_inv_idx = IdxW'(lowest_set(MaxEntries'(first_inv_oh)));

  assign sel_idx = any_inv ? first_inv_idx : plru_idx;
  assign sel_oh  = any_inv ? first_inv_oh  : plru_oh;

  // A write touch overrides a same-cycle hit; multi-hit never touches.
  assign write_touch = (state_q == WRITE);
  assign touch_en    = write_touch | (hit & hit_onehot);
  assign touch_idx   = write_touch ? victim_q : hit_idx;

  tlb_plru #(
    .TLB_ENTRIES (TLB_ENTRIES)
  ) u_plru (
    .clk          (clk),
    .reset        (reset),
    .touch_en_i   (touch_en),
    .touch_idx_i  (touch_idx),
    .victim_idx_o (plru_idx),
    .victim_oh_o  (plru_oh)
  );

  always_comb begin
    state_d  = state_q;
    victim_d = victim_q;
    we_d     = '0;
    ack_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A same-cycle flush wins; the held request is taken next cycle.
        if (bus.FillReq && !bus.FlushReq) begin
          state_d  = WRITE;
          victim_d = sel_idx;
          we_d     = sel_oh;
        end
      end
      WRITE: begin
        state_d = ACK;
        ack_d   = 1'b1;
      end
      ACK: begin
        state_d = DRAIN;
      end
      DRAIN: begin
        if (!bus.FillReq) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // The write sets its entry first so a coincident flush is applied on top.
  always_comb begin
    valid_d = valid_q;
    if (state_q == WRITE) valid_d[victim_q] = 1'b1;
    if (bus.FlushReq) begin
      valid_d = bus.FlushAll ? '0 : (valid_d & bus.PTE_Gs);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      victim_q <= '0;
      we_q     <= '0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      we_q     <= we_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.WriteEnables = we_q;
  assign bus.FillAck      = ack_q;
  assign bus.Valid        = valid_q;
  assign bus.Busy         = busy_q;
  assign bus.TLBHit       = hit;

endmodule

// File: tb/tb_tlb_fill_ctrl.sv
// Scoreboard bench for tlb_fill_ctrl: each fill pushes its predicted
// WriteEnables strobe, a negedge monitor pops and compares every strobe.
module tb_tlb_fill_ctrl;

  localparam int N = 8;
  localparam int L = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tlb_fill_ctrl_if #(.TLB_ENTRIES(N)) bus ();

  tlb_fill_ctrl #(
    .TLB_ENTRIES (N)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int we_pulses = 0;
  logic [N-1:0] sb_q[$];
  logic [N-1:0] exp_we;
  logic [N-1:0] valid_m;
  logic [N-2:0] plru_m;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Reference tree: level l node for entry e is (1<<l) + (e >> (L-l)).
  task automatic model_touch(input int e);
    for (int l = 0; l < L; l++) begin
      int n;
      n = (1 << l) + (e >> (L - l));
      plru_m[n-1] = ~e[L-1-l];
    end
  endtask

  function automatic int model_victim();
    int v;
    if (valid_m != '1) begin
      for (int i = N - 1; i >= 0; i--) if (!valid_m[i]) v = i;
      return v;
    end
    v = 0;
    for (int l = 0; l < L; l++) v = (v << 1) | int'(plru_m[(1 << l) + v - 1]);
    return v;
  endfunction

  always @(negedge clk) begin
    if (bus.WriteEnables !== '0) begin
      we_pulses++;
      if (sb_q.size() == 0) begin
        check_eq("we_unexpected", 32'(bus.WriteEnables), 32'd0);
      end else begin
        exp_we = sb_q.pop_front();
        check_eq("we", 32'(bus.WriteEnables), 32'(exp_we));
      end
    end
  end

  task automatic do_fill(input bit flush_first, input int hold);
    int v, lat, exp_lat, p0;
    bit got;
    @(posedge clk); #1;
    bus.FillReq = 1'b1;
    if (flush_first) begin
      bus.FlushReq = 1'b1;
      bus.FlushAll = 1'b1;
      valid_m = '0;
    end
    v = model_victim();
    sb_q.push_back(N'(1) << v);
    p0 = we_pulses;
    if (flush_first) begin
      @(posedge clk); #1;
      bus.FlushReq = 1'b0;
      bus.FlushAll = 1'b0;
      @(negedge clk);
      check_eq("flush_fill_valid", 32'(bus.Valid), 32'd0);
      check_eq("flush_fill_busy", 32'(bus.Busy), 32'd0);
      exp_lat = 2;
    end else begin
      exp_lat = 3;
    end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      if (bus.FillAck) got = 1'b1;
    end
    if (!got) check_eq("ack_timeout", 32'd0, 32'd1);
    else check_eq("ack_latency", 32'(lat), 32'(exp_lat));
    valid_m[v] = 1'b1;
    model_touch(v);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("drain_busy", 32'(bus.Busy), 32'd1);
      check_eq("drain_noack", 32'(bus.FillAck), 32'd0);
    end
    @(posedge clk); #1;
    bus.FillReq = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("idle_busy", 32'(bus.Busy), 32'd0);
    check_eq("one_pulse", 32'(we_pulses - p0), 32'd1);
    check_eq("valid", 32'(bus.Valid), 32'(valid_m));
  endtask

  task automatic do_hit(input logic [N-1:0] m);
    @(posedge clk); #1;
    bus.TLBAccess = 1'b1;
    bus.Matches   = m;
    @(negedge clk);
    check_eq("tlbhit", 32'(bus.TLBHit), 32'd1);
    @(posedge clk); #1;
    bus.TLBAccess = 1'b0;
    bus.Matches   = '0;
    if ($onehot(m)) begin
      for (int i = 0; i < N; i++) if (m[i]) model_touch(i);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset         = 1'b1;
    bus.TLBAccess = 1'b0;
    bus.Matches   = '0;
    bus.PTE_Gs    = '0;
    bus.FillReq   = 1'b0;
    bus.FlushReq  = 1'b0;
    bus.FlushAll  = 1'b0;
    valid_m       = '0;
    plru_m        = '0;
    #23;
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_valid", 32'(bus.Valid), 32'd0);
    check_eq("rst_we", 32'(bus.WriteEnables), 32'd0);
    check_eq("rst_ack", 32'(bus.FillAck), 32'd0);
    check_eq("rst_busy", 32'(bus.Busy), 32'd0);

    // Fill every entry in order.
    for (int i = 0; i < N; i++) do_fill(1'b0, 0);
    check_eq("all_valid", 32'(bus.Valid), 32'hFF);

    // Miss does not hit.
    @(posedge clk); #1;
    bus.TLBAccess = 1'b1;
    @(negedge clk);
    check_eq("miss", 32'(bus.TLBHit), 32'd0);
    @(posedge clk); #1;
    bus.TLBAccess = 1'b0;

    // PLRU victims once full.
    do_hit(8'h01);
    do_fill(1'b0, 0);
    do_hit(8'h10);
    do_fill(1'b0, 0);
    // Multi-hit must leave the tree untouched.
    do_hit(8'h11);
    do_fill(1'b0, 0);

    // Non-global flush.
    bus.PTE_Gs = 8'h0F;
    @(posedge clk); #1;
    bus.FlushReq = 1'b1;
    bus.FlushAll = 1'b0;
    @(posedge clk); #1;
    bus.FlushReq = 1'b0;
    valid_m = valid_m & 8'h0F;
    @(negedge clk);
    check_eq("flush_nonglobal", 32'(bus.Valid), 32'h0F);
    do_fill(1'b0, 0);

    // Flush-all with a coincident fill request, then a long DRAIN.
    do_fill(1'b1, 0);
    do_fill(1'b0, 5);

    // Reset in the middle of WRITE.
    @(posedge clk); #1;
    bus.FillReq = 1'b1;
    sb_q.push_back(N'(1) << model_victim());
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_eq("rst_mid_we", 32'(bus.WriteEnables), 32'd0);
    check_eq("rst_mid_busy", 32'(bus.Busy), 32'd0);
    check_eq("rst_mid_valid", 32'(bus.Valid), 32'd0);
    bus.FillReq = 1'b0;
    valid_m = '0;
    plru_m  = '0;
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("rst_mid_noack", 32'(bus.FillAck), 32'd0);
    end
    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
